// File: rtl/perf_sig_monitor.sv
// perf_sig_monitor: passive observer on the rv32i data-memory write bus and
// fetch PC. Counts run cycles, PC changes and stores from enable until the
// program writes its PASS flag, and keeps a byte-lane accurate copy of the
// 4-word signature region so results can be read without touching d_mem.
module perf_sig_monitor #(
  parameter logic [7:0]  PASS_ADDR      = 8'h08,
  parameter logic [7:0]  SIG_BASE       = 8'h80,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        en,
  input  logic        clr,
  input  logic [7:0]  pc,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [1:0]  mode,
  input  logic [31:0] d_in,
  input  logic [1:0]  sig_sel,
  output logic [31:0] sig_data,
  output logic [31:0] cycle_cnt,
  output logic [31:0] fetch_cnt,
  output logic [15:0] store_cnt,
  output logic        done,
  output logic        pass,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TOUT = 2'd3
  } state_t;

  // Value of cycle_cnt during the last cycle that may still end in a PASS.
  localparam logic [31:0] TOUT_LAST = 32'(TIMEOUT_CYCLES - 32'd1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  pc_q;
  logic [31:0] sig [4];

  logic        in_run;
  logic        pass_hit;
  logic        pass_val;
  logic        sig_hit;
  logic        tout_hit;
  logic [3:0]  lane_en;
  logic [31:0] lane_data;

  assign in_run   = (state == RUN);
  assign pass_hit = wr_en && (wr_addr[7:2] == PASS_ADDR[7:2]);
  // Mode 11 is treated as a word store, so only mode[1] matters here.
  assign pass_val = mode[1] && (d_in == 32'h1);
  assign sig_hit  = wr_en && (wr_addr[7:4] == SIG_BASE[7:4]);
  assign tout_hit = (cycle_cnt == TOUT_LAST);
  assign sig_data = sig[sig_sel];

  // Byte-lane enables and lane-replicated data for the store being observed.
  always_comb begin
    lane_en   = 4'b1111;
    lane_data = d_in;
    case (mode)
      2'b00: begin
        lane_en   = 4'b0001 << wr_addr[1:0];
        lane_data = {4{d_in[7:0]}};
      end
      2'b01: begin
        lane_en   = wr_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{d_in[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = d_in;
      end
    endcase
  end

  // Next-state: a PASS store beats a timeout landing in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN: begin
        if (pass_hit)      state_nxt = DONE;
        else if (tout_hit) state_nxt = TOUT;
      end
      default: state_nxt = state;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // State register and the previous-PC tracker, which loads in every state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      pc_q  <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc;
    end
  end

  // Run counters; they only advance in RUN, store_cnt saturates.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cycle_cnt <= '0;
      fetch_cnt <= '0;
      store_cnt <= '0;
    end else if (clr) begin
      cycle_cnt <= '0;
      fetch_cnt <= '0;
      store_cnt <= '0;
    end else if (in_run) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (pc != pc_q)                    fetch_cnt <= fetch_cnt + 32'd1;
      if (wr_en && store_cnt != 16'hFFFF) store_cnt <= store_cnt + 16'd1;
    end
  end

  // Sticky result flags, set on the edge of the deciding RUN cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      done    <= 1'b0;
      pass    <= 1'b0;
      timeout <= 1'b0;
    end else if (clr) begin
      done    <= 1'b0;
      pass    <= 1'b0;
      timeout <= 1'b0;
    end else if (in_run) begin
      if (pass_hit) begin
        done <= 1'b1;
        pass <= pass_val;
      end else if (tout_hit) begin
        timeout <= 1'b1;
      end
    end
  end

  // Signature capture, byte-lane merged; the store that ends the run still lands.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int w = 0; w < 4; w++) sig[w] <= '0;
    end else if (clr) begin
      for (int w = 0; w < 4; w++) sig[w] <= '0;
    end else if (in_run && sig_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) sig[wr_addr[3:2]][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

endmodule
